display_timing_480p: RTL
========================

# display_timing_480p

Pixel-clock-domain display timing generator for 640x480 @ 60 Hz (25.2 MHz nominal clk_pix). Sits directly upstream of the pixel painting and bounce-motion logic in the top level. Produces registered screen coordinates, sync, data-enable, per-line/per-frame strobes and an optional frame counter. The motion logic steps on vbl instead of edge-detecting vsync.

## Interface
- CORDW, 10: width of sx/sy in bits; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync asserted level; 0 = active-low, 1 = active-high.
- FCW, 16: frame_cnt width.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- clk_pix  input  1  pixel clock; only clock.
- btn_rst_n  input  1  asynchronous, active-low reset.
- sx  output  CORDW  horizontal position, unsigned, 0..H_TOTAL-1.
- sy  output  CORDW  vertical position, unsigned, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, level per SYNC_POL.
- vsync  output  1  vertical sync, level per SYNC_POL.
- de  output  1  high while in the active area.
- line  output  1  one-cycle strobe at the start of every line.
- frame  output  1  one-cycle strobe at the start of every frame.
- vbl  output  1  one-cycle strobe at the start of vertical blanking.
- frame_cnt  output  FCW  count of frames since reset.

## Operation
- sx increments every clk_pix cycle. At H_TOTAL-1 it wraps to 0 and sy advances.
- sy wraps from V_TOTAL-1 to 0 on the same cycle that sx wraps.
- Decode as a pure function of the sx/sy values on the same cycle:
  - de = (sx < H_ACTIVE) && (sy < V_ACTIVE).
  - hsync asserted iff H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted iff V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (490..491).
  - line = (sx == 0), including during vertical blanking.
  - frame = (sx == 0 && sy == 0).
  - vbl = (sx == 0 && sy == V_ACTIVE).
- All outputs come directly from flops, with no combinational path to the ports. Decode is therefore computed from next-state counter values.
- Reset (btn_rst_n low, asynchronous):
  - sx = H_TOTAL-1, sy = V_TOTAL-1.
  - de = 0; hsync and vsync deasserted (= !SYNC_POL); line, frame and vbl all 0.
  - frame_cnt = all ones.
  - These values are consistent with the decode rules, so there is no glitch on release.
- First rising edge after reset release: sx=0, sy=0, de=1, line=1, frame=1, frame_cnt=0.
- Reset asserted mid-frame: all outputs immediately take their reset values. Timing restarts from frame start as above.

## Timing
- Counter period is H_TOTAL cycles per line and H_TOTAL*V_TOTAL (420000) cycles per frame.
- Output latency is 0: every output corresponds to the sx/sy presented on the same cycle.
- frame and line coincide on the frame-start cycle. vbl and line coincide on line V_ACTIVE.
- frame_cnt increments on the cycle frame is high and holds that value for the rest of the frame. It wraps from 2^FCW-1 to 0 with no flag.
- vbl precedes vsync assertion by V_FP lines (8000 cycles).

## Configuration
- TIMING_FRAME_CNT_EN defined: the frame_cnt counter is implemented as described above.
- TIMING_FRAME_CNT_EN undefined:
  - frame_cnt is tied to 0 and no counter flops are built.
  - The port is still present.
  - All other behaviour is identical.

## Test plan
- Reset release: hold btn_rst_n low for 5 cycles, then release. Next edge gives sx=0, sy=0, de=1, frame=1, line=1, frame_cnt=0.
- Line decode on line 0:
  - de falls when sx goes 639 to 640.
  - hsync (SYNC_POL=0) is low for exactly sx 656..751, i.e. 96 cycles.
  - sx wraps 799 to 0 with sy 0 to 1, and line=1 on that cycle.
- Frame decode over one full frame:
  - vbl occurs once, at sx=0, sy=480.
  - vsync is low for sy 490..491, i.e. 1600 cycles.
  - The next frame strobe comes exactly 420000 cycles after the previous one.
  - de is high for exactly 307200 cycles per frame.
- Mid-frame reset: pulse btn_rst_n low at sx=300, sy=200 for 1 cycle.
  - While low, outputs are at reset values (de=0, sx=799, sy=524).
  - On release, the sequence restarts at frame start.
- frame_cnt wrap (FCW=2, macro defined): across 5 frames frame_cnt reads 0,1,2,3,0. With the macro undefined it reads 0 throughout.
- SYNC_POL=1: hsync and vsync are inverted relative to the default. All other outputs are unchanged cycle-for-cycle.

Source files
------------

// File: rtl/display_timing_480p.sv
// ---------------------------------------------------------------------------
// display_timing_480p
//
// Purpose:
//   Display timing generator for the pixel-clock domain. The default
//   parameters give 640x480 at 60 Hz, with a nominal clk_pix of 25.2 MHz.
//   It produces registered screen coordinates, the sync pulses, data
//   enable, a strobe per line, a strobe per frame, a strobe at the start of
//   vertical blanking and an optional frame counter.
//
// Every output comes straight from a flop. The decode is done on the
// next-state counter values, so each output matches the sx/sy shown on the
// same cycle (zero latency).
//
// Ports:
//   clk_pix    in   1      pixel clock (only clock)
//   btn_rst_n  in   1      asynchronous, active-low reset
//   sx         out  CORDW  horizontal position, 0..H_TOTAL-1
//   sy         out  CORDW  vertical position, 0..V_TOTAL-1
//   hsync      out  1      horizontal sync, asserted level = SYNC_POL
//   vsync      out  1      vertical sync, asserted level = SYNC_POL
//   de         out  1      high inside the active area
//   line       out  1      one-cycle strobe at sx == 0
//   frame      out  1      one-cycle strobe at sx == 0, sy == 0
//   vbl        out  1      one-cycle strobe at sx == 0, sy == V_ACTIVE
//   frame_cnt  out  FCW    frames since reset (wraps silently)
//
// Configuration macro:
//   TIMING_FRAME_CNT_EN  defined   -> frame_cnt counter is built
//                        undefined -> frame_cnt is tied to 0 and no
//                                     counter flops are built
// ---------------------------------------------------------------------------
module display_timing_480p #(
  parameter int CORDW    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int FCW      = 16
) (
  input  logic             clk_pix,
  input  logic             btn_rst_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic             vbl,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundary values, sized to the coordinate width for the comparisons
  localparam logic [CORDW-1:0] H_LAST_C   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST_C   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT_C    = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT_C    = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START_C = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END_C   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START_C = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END_C   = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] ONE_C      = CORDW'(1);
  localparam logic [CORDW-1:0] ZERO_C     = CORDW'(0);

  // Asserted and idle levels of the sync outputs
  localparam logic SYNC_ON_C  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF_C = (SYNC_POL != 0) ? 1'b0 : 1'b1;

  logic [CORDW-1:0] sx_next_s;
  logic [CORDW-1:0] sy_next_s;
  logic             de_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;
  logic             line_next_s;
  logic             frame_next_s;
  logic             vbl_next_s;

  // Next counter position: sx wraps at the line end, and sy advances (or
  // wraps) on the same cycle
  always_comb begin
    sx_next_s = sx;
    sy_next_s = sy;
    if (sx == H_LAST_C) begin
      sx_next_s = ZERO_C;
      if (sy == V_LAST_C) begin
        sy_next_s = ZERO_C;
      end else begin
        sy_next_s = sy + ONE_C;
      end
    end else begin
      sx_next_s = sx + ONE_C;
      sy_next_s = sy;
    end
  end

  // Decode the next position so the registered outputs line up with the
  // registered coordinates
  always_comb begin
    de_next_s    = (sx_next_s < H_ACT_C) && (sy_next_s < V_ACT_C);
    line_next_s  = (sx_next_s == ZERO_C);
    frame_next_s = (sx_next_s == ZERO_C) && (sy_next_s == ZERO_C);
    vbl_next_s   = (sx_next_s == ZERO_C) && (sy_next_s == V_ACT_C);
    if ((sx_next_s >= HS_START_C) && (sx_next_s < HS_END_C)) begin
      hsync_next_s = SYNC_ON_C;
    end else begin
      hsync_next_s = SYNC_OFF_C;
    end
    if ((sy_next_s >= VS_START_C) && (sy_next_s < VS_END_C)) begin
      vsync_next_s = SYNC_ON_C;
    end else begin
      vsync_next_s = SYNC_OFF_C;
    end
  end

  // Coordinate and decode registers. The reset position is the last pixel of
  // the last line, so the first edge after release lands on frame start
  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      sx    <= H_LAST_C;
      sy    <= V_LAST_C;
      de    <= 1'b0;
      hsync <= SYNC_OFF_C;
      vsync <= SYNC_OFF_C;
      line  <= 1'b0;
      frame <= 1'b0;
      vbl   <= 1'b0;
    end else begin
      sx    <= sx_next_s;
      sy    <= sy_next_s;
      de    <= de_next_s;
      hsync <= hsync_next_s;
      vsync <= vsync_next_s;
      line  <= line_next_s;
      frame <= frame_next_s;
      vbl   <= vbl_next_s;
    end
  end

`ifdef TIMING_FRAME_CNT_EN
  // Frame counter. It resets to all ones so that the first frame strobe
  // rolls it over to 0
  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      frame_cnt <= '1;
    end else if (frame_next_s) begin
      frame_cnt <= frame_cnt + FCW'(1);
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`else
  // Counter not built: the port is tied low
  assign frame_cnt = '0;
`endif

endmodule
